// File: rtl/pwm_peripheral.sv
// PWM output block: prescaler, 8-bit period counter, shadowed duty register
// and a registered per-lane output stage for the 16 chip output bits.
module pwm_peripheral #(
  parameter int DIV   = 1,
  parameter int DIV_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic       period_start
);

  localparam int               NUM_LANES = 16;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);

  logic [DIV_W-1:0]     div_cnt;
  logic [7:0]           pwm_cnt;
  logic [7:0]           duty_active;
  logic                 tick;
  logic                 wrap;
  logic                 pwm_level;
  logic [NUM_LANES-1:0] out_en;
  logic [NUM_LANES-1:0] pwm_en;
  logic [NUM_LANES-1:0] lane_q;

  // With DIV=1 div_cnt never leaves 0, so tick is permanently high.
  assign tick = (div_cnt == DIV_LAST);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  // Full duty is forced high so the cnt=255 slot does not produce a 1-tick dip.
  assign pwm_level = (duty_active == 8'hFF) || (pwm_cnt < duty_active);

  assign out_en = {en_reg_out_15_8, en_reg_out_7_0};
  assign pwm_en = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign {uio_out, uo_out} = lane_q;

  // Prescaler: count 0..DIV-1, wrapping on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Free-running period counter, wraps 255 -> 0 naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pwm_cnt <= '0;
    else if (tick) pwm_cnt <= pwm_cnt + 8'd1;
  end

  // Duty shadow and boundary pulse: the new duty lands together with cnt=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_active  <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (wrap) duty_active <= pwm_duty_cycle;
    end
  end

  // Per-lane registered output; all lanes share one pwm_level so they stay phase-aligned.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lane_q[i] <= 1'b0;
      else        lane_q[i] <= out_en[i] & (~pwm_en[i] | pwm_level);
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: DIV=1 and DIV=4 instances share stimulus and are
// both tracked by a clock-count based reference model every cycle.
module tb_pwm_peripheral;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] en_out_lo = '0, en_out_hi = '0, en_pwm_lo = '0, en_pwm_hi = '0, duty = '0;
  logic [7:0] uo1, uio1, uo4, uio4;
  logic       ps1, ps4;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;                 // clk edges since reset release
  int duty_m [2] = '{0, 0};  // model's view of the duty in force, per instance
  int divs   [2] = '{1, 4};

  always #5 clk = ~clk;

  pwm_peripheral #(.DIV(1), .DIV_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(en_out_lo), .en_reg_out_15_8(en_out_hi),
    .en_reg_pwm_7_0(en_pwm_lo), .en_reg_pwm_15_8(en_pwm_hi),
    .pwm_duty_cycle(duty), .uo_out(uo1), .uio_out(uio1), .period_start(ps1)
  );

  pwm_peripheral #(.DIV(4), .DIV_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(en_out_lo), .en_reg_out_15_8(en_out_hi),
    .en_reg_pwm_7_0(en_pwm_lo), .en_reg_pwm_15_8(en_pwm_hi),
    .pwm_duty_cycle(duty), .uo_out(uo4), .uio_out(uio4), .period_start(ps4)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h, want %0h (n=%0d)", name, act, exp, n);
    end
  endtask

  // One clk: predict from ticks elapsed (n/DIV), advance, compare both instances.
  task automatic step();
    logic [7:0] eu [2];
    logic [7:0] ei [2];
    logic       ep [2];
    int         tp, tn;
    logic       lvl;
    for (int d = 0; d < 2; d++) begin
      tp     = n / divs[d];
      tn     = (n + 1) / divs[d];
      lvl    = (duty_m[d] == 255) || ((tp % 256) < duty_m[d]);
      eu[d]  = en_out_lo & (~en_pwm_lo | {8{lvl}});
      ei[d]  = en_out_hi & (~en_pwm_hi | {8{lvl}});
      ep[d]  = (tn != tp) && (tn % 256 == 0);
      if (ep[d]) duty_m[d] = int'(duty);
    end
    @(posedge clk); #1;
    n++;
    chk("uo_div1",  int'(uo1),  int'(eu[0]));
    chk("uio_div1", int'(uio1), int'(ei[0]));
    chk("ps_div1",  int'(ps1),  int'(ep[0]));
    chk("uo_div4",  int'(uo4),  int'(eu[1]));
    chk("uio_div4", int'(uio4), int'(ei[1]));
    chk("ps_div4",  int'(ps4),  int'(ep[1]));
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_uo1"},  int'(uo1),  0);
    chk({name, "_uio1"}, int'(uio1), 0);
    chk({name, "_ps1"},  int'(ps1),  0);
    chk({name, "_uo4"},  int'(uo4),  0);
    chk({name, "_uio4"}, int'(uio4), 0);
    chk({name, "_ps4"},  int'(ps4),  0);
  endtask

  // Assert reset at posedge+1 (asynchronous), hold, release at posedge+1.
  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk_zero("rst_hold");
    end
    rst_n  = 1'b1;
    n      = 0;
    duty_m = '{0, 0};
  endtask

  // Step until the selected instance shows period_start; cnt = steps taken.
  task automatic wait_ps(input int d, output int cnt);
    cnt = 0;
    for (int k = 0; k < 1100; k++) begin
      step();
      cnt++;
      if ((d == 0) ? ps1 : ps4) return;
    end
    chk("ps_timeout", 0, 1);
  endtask

  typedef struct {
    logic [7:0] duty;
    logic [7:0] en_out;
    logic [7:0] en_pwm;
    logic [7:0] hi_pat;
    logic [7:0] lo_pat;
    int         exp_hi;
  } vec_t;

  initial begin
    vec_t tbl [8];
    int   cnt, hi, bad, early;

    tbl[0] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 0};
    tbl[1] = '{8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h00, 128};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 256};
    tbl[3] = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1};
    tbl[4] = '{8'h40, 8'hFF, 8'hFF, 8'hFF, 8'h00, 64};
    tbl[5] = '{8'hC0, 8'hF0, 8'h30, 8'hF0, 8'hC0, 192};
    tbl[6] = '{8'hFE, 8'hA5, 8'hFF, 8'hA5, 8'h00, 254};
    tbl[7] = '{8'h55, 8'h0F, 8'h00, 8'h0F, 8'h0F, 256};

    @(posedge clk); #1;
    do_reset(3);

    // Table: set config, let it be captured at a boundary, then measure one full period.
    foreach (tbl[i]) begin
      duty = tbl[i].duty;
      en_out_lo = tbl[i].en_out; en_out_hi = tbl[i].en_out;
      en_pwm_lo = tbl[i].en_pwm; en_pwm_hi = tbl[i].en_pwm;
      wait_ps(0, cnt);
      hi = 0; bad = 0;
      for (int k = 0; k < 256; k++) begin
        step();
        if (uo1 == tbl[i].hi_pat && uio1 == tbl[i].hi_pat) hi++;
        else if (!(uo1 == tbl[i].lo_pat && uio1 == tbl[i].lo_pat)) bad++;
      end
      chk($sformatf("tbl%0d_hi_cycles", i), hi, tbl[i].exp_hi);
      chk($sformatf("tbl%0d_stray", i), bad, 0);
    end

    // Period spacing at DIV=1 and DIV=4.
    wait_ps(0, cnt);
    wait_ps(0, cnt);
    chk("ps_spacing_div1", cnt, 256);
    wait_ps(1, cnt);
    wait_ps(1, cnt);
    chk("ps_spacing_div4", cnt, 1024);

    // Reset mid-period with duty 0x80 active.
    duty = 8'h80; en_out_lo = 8'hFF; en_pwm_lo = 8'hFF; en_out_hi = 8'hFF; en_pwm_hi = 8'hFF;
    wait_ps(0, cnt);
    for (int k = 0; k < 100; k++) step();
    do_reset(3);
    hi = 0; early = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (uo1 != 8'h00) hi++;
      if (ps1 && k < 255) early++;
    end
    chk("post_rst_first_ps", int'(ps1), 1);
    chk("post_rst_early_ps", early, 0);
    chk("post_rst_uo_high", hi, 0);

    // Shadowing: 0x40 in force, 0xC0 written at cnt=10.
    duty = 8'h40;
    wait_ps(0, cnt);
    wait_ps(0, cnt);
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      if (k == 10) duty = 8'hC0;
      step();
      if (uo1 == 8'hFF) hi++;
    end
    chk("shadow_cur_hi", hi, 64);
    chk("shadow_boundary", int'(ps1), 1);
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (uo1 == 8'hFF) hi++;
    end
    chk("shadow_next_hi", hi, 192);

    // Mixed enables on the high byte, then clear output enables mid-period.
    duty = 8'h80; en_out_hi = 8'hF0; en_pwm_hi = 8'h30;
    wait_ps(0, cnt);
    for (int k = 0; k < 20; k++) step();
    chk("mixed_hi_phase", int'(uio1), 8'hF0);
    for (int k = 0; k < 130; k++) step();
    chk("mixed_lo_phase", int'(uio1), 8'hC0);
    en_out_hi = 8'h00;
    step();
    chk("en_clear_next_clk", int'(uio1), 0);

    // DIV=4 with duty 0x40: 256 clk high out of 1024.
    duty = 8'h40; en_out_lo = 8'hFF; en_pwm_lo = 8'hFF;
    wait_ps(1, cnt);
    wait_ps(1, cnt);
    hi = 0;
    for (int k = 0; k < 1024; k++) begin
      step();
      if (uo4 == 8'hFF) hi++;
    end
    chk("div4_hi_cycles", hi, 256);
    chk("div4_boundary", int'(ps4), 1);

    // Random segments, including edge duties and a random mid-run reset.
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 3))
        0:       duty = 8'h00;
        1:       duty = 8'hFF;
        default: duty = 8'($urandom);
      endcase
      en_out_lo = 8'($urandom); en_out_hi = 8'($urandom);
      en_pwm_lo = 8'($urandom); en_pwm_hi = 8'($urandom);
      if (s == 20) do_reset($urandom_range(1, 4));
      for (int k = 0, m = $urandom_range(1, 300); k < m; k++) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Consumes the five configuration registers written over SPI (output enables, PWM enables, duty cycle) and drives the 16 chip outputs uo_out[7:0] and uio_out[7:0]. It contains a prescaler, an 8-bit free-running PWM period counter and a shadow duty register, so duty updates take effect only at period boundaries. All outputs are registered.

Parameters:
DIV, 1, prescaler ratio in clk cycles per PWM counter tick; legal values are 1 to 65535.
DIV_W, 16, width of the prescaler counter; must hold DIV-1.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
en_reg_out_7_0  input  8  per-bit output enable for uo_out
en_reg_out_15_8  input  8  per-bit output enable for uio_out
en_reg_pwm_7_0  input  8  per-bit PWM select for uo_out (1 = PWM, 0 = static high)
en_reg_pwm_15_8  input  8  per-bit PWM select for uio_out
pwm_duty_cycle  input  8  requested duty cycle (0x00 = 0%, 0xFF = 100%)
uo_out  output  8  registered output bits 7:0
uio_out  output  8  registered output bits 15:8
period_start  output  1  one-clk pulse at each PWM period boundary

Behaviour:
- Reset (async, rst_n=0):
  - div_cnt=0, pwm_cnt=0, duty_active=0.
  - uo_out=0, uio_out=0, period_start=0.
  - Applies at any point mid-period. The first period after release starts at pwm_cnt=0.
- Inputs are synchronous to clk because they come from the SPI register stage. No synchronizers.
- Prescaler:
  - div_cnt counts 0..DIV-1 and then wraps to 0.
  - tick=1 in every cycle where div_cnt==DIV-1.
  - With DIV=1, tick is constantly 1.
- Period counter:
  - pwm_cnt increments by 1 on each tick and wraps from 255 to 0 (mod 256).
  - One PWM period is 256 ticks, i.e. 256*DIV clk.
- Period boundary: wrap = tick && pwm_cnt==255. On wrap:
  - duty_active <= pwm_duty_cycle.
  - period_start <= 1.
  - In all other cycles period_start <= 0.
- Duty shadowing:
  - pwm_duty_cycle changes mid-period have no effect until the next wrap.
  - duty_active=0 from reset until the first wrap, so PWM-mode outputs are low during the first period.
- PWM level (combinational):
  - pwm_level = 1 if duty_active==0xFF.
  - Otherwise pwm_level = (pwm_cnt < duty_active).
  - Result: duty 0x00 is constantly low. Duty N in 1..254 is high for N of 256 ticks, starting at pwm_cnt=0. Duty 0xFF is constantly high (no 1-tick glitch).
- Output stage (registered, 1-clk latency from pwm_cnt, duty_active and enable inputs):
  - uo_out[i] <= en_reg_out_7_0[i] & (~en_reg_pwm_7_0[i] | pwm_level).
  - uio_out[i] <= en_reg_out_15_8[i] & (~en_reg_pwm_15_8[i] | pwm_level).
  - Per-bit truth: out_en=0 gives 0 regardless of the PWM bit. out_en=1 with pwm_en=0 gives 1. out_en=1 with pwm_en=1 gives pwm_level.
- Enable changes are not shadowed; they take effect on the next clk edge.
- All 16 PWM bits share one pwm_level and are therefore phase-aligned.
- Simultaneous events: if pwm_duty_cycle changes in the same cycle as wrap, the new value is captured. If an enable changes in the same cycle as wrap, both updates apply independently.
- Deriving DIV: PWM frequency = f_clk / (256*DIV). With a 10 MHz clk, DIV=13 gives about 3 kHz.

Test Plan:
1. Reset mid-period (DIV=1, duty 0x80 active, pwm_cnt≈100), pulse rst_n low for 3 clk -> all outputs 0 during reset; after release, period_start is first seen 256 clk later and uo_out stays low through the first period.
2. DIV=1, en_reg_out_7_0=0xFF, en_reg_pwm_7_0=0xFF, pwm_duty_cycle=0x80 -> after the first period_start, uo_out=0xFF for exactly 128 clk then 0x00 for 128 clk, repeating; period_start is spaced 256 clk apart.
3. Duty extremes, DIV=1: 0x00 -> uo_out never high over 3 periods; 0xFF -> uo_out=0xFF continuously with no low cycle across a wrap; 0x01 -> high for 1 clk per period.
4. Shadowing, DIV=1, duty=0x40: at pwm_cnt=10 write 0xC0 -> current period stays high 64 clk; the next period is high 192 clk.
5. Mixed enables: en_reg_out_15_8=0xF0, en_reg_pwm_15_8=0x30, duty=0x80 -> uio_out[7:6]=1 static; uio_out[5:4] toggle with PWM; uio_out[3:0]=0. Clearing en_reg_out_15_8 drives uio_out to 0 one clk later, mid-period.
6. DIV=4, duty=0x40 -> high for 256 clk, low for 768 clk; period_start spacing is 1024 clk; tick asserts every 4th clk.
